float_mul_nb: RTL and testbench

Multi-cycle IEEE-754 single-precision multiplier with a valid-pulse interface. It is the counterpart of `float_div_nb`: in the JPEG quantiser path it re-scales dequantised and reciprocal-quantised coefficients. It uses an iterative shift-add mantissa datapath to keep area small. Latency is fixed regardless of operand values, so downstream blocks can count cycles.

---
 rtl/float_mul_nb.sv | 175 +++++++++++++++++
 tb/tb_float_mul_nb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_mul_nb.sv
// float_mul_nb: fixed-latency iterative shift-add IEEE-754 binary32 multiplier (flush-to-zero, RNE).
// Define FLOAT_MUL_NB_RADIX4_EN to retire two multiplier bits per cycle (12 iterations instead of 24).
module float_mul_nb (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] din1,
    input  logic [31:0] din2,
    input  logic        din_valid,
    output logic [31:0] dout,
    output logic        dout_valid
);
`ifdef FLOAT_MUL_NB_RADIX4_EN
    localparam logic [4:0] LAST_ITER = 5'd11;
`else
    localparam logic [4:0] LAST_ITER = 5'd23;
`endif

    typedef enum logic [1:0] {IDLE, MUL, RND} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

    state_t      r_state, w_next_state;
    special_t    r_special, w_special;
    logic        r_sign;
    logic [7:0]  r_exp_a, r_exp_b;
    logic [47:0] r_mcand;
    logic [23:0] r_mplier;
    logic [47:0] r_acc;
    logic [4:0]  r_cnt;
    logic [31:0] r_dout;
    logic        r_dout_valid;
    logic [47:0] w_addend;
    logic [31:0] w_result;

    logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    assign w_a_nan  = (din1[30:23] == 8'hFF) && (din1[22:0] != 23'd0);
    assign w_b_nan  = (din2[30:23] == 8'hFF) && (din2[22:0] != 23'd0);
    assign w_a_inf  = (din1[30:23] == 8'hFF) && (din1[22:0] == 23'd0);
    assign w_b_inf  = (din2[30:23] == 8'hFF) && (din2[22:0] == 23'd0);
    assign w_a_zero = (din1[30:23] == 8'h00);
    assign w_b_zero = (din2[30:23] == 8'h00);

    // Special-case class is decided once at capture; NaN outranks inf*zero outranks inf outranks zero
    always_comb begin
        w_special = SP_NONE;
        if (w_a_nan || w_b_nan)
            w_special = SP_NAN;
        else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
            w_special = SP_NAN;
        else if (w_a_inf || w_b_inf)
            w_special = SP_INF;
        else if (w_a_zero || w_b_zero)
            w_special = SP_ZERO;
    end

`ifdef FLOAT_MUL_NB_RADIX4_EN
    logic [47:0] r_mcand3;
    logic [25:0] w_a3;
    assign w_a3 = {2'b00, 1'b1, din1[22:0]} + {1'b0, 1'b1, din1[22:0], 1'b0};

    always_comb begin
        w_addend = '0;
        case (r_mplier[1:0])
            2'd1:    w_addend = r_mcand;
            2'd2:    w_addend = r_mcand << 1;
            2'd3:    w_addend = r_mcand3;
            default: w_addend = '0;
        endcase
    end
`else
    assign w_addend = r_mplier[0] ? r_mcand : 48'd0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (din_valid) w_next_state = MUL;
            MUL:     if (r_cnt == LAST_ITER) w_next_state = RND;
            RND:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Normalise a [1,4) product, then round to nearest-even on guard/sticky
    logic        w_norm, w_guard, w_sticky, w_round_up;
    logic [22:0] w_frac;
    logic [23:0] w_frac_rnd;
    logic [9:0]  w_exp_pre, w_exp_fin;
    assign w_norm     = r_acc[47];
    assign w_frac     = w_norm ? r_acc[46:24] : r_acc[45:23];
    assign w_guard    = w_norm ? r_acc[23] : r_acc[22];
    assign w_sticky   = w_norm ? (|r_acc[22:0]) : (|r_acc[21:0]);
    assign w_round_up = w_guard & (w_sticky | w_frac[0]);
    assign w_frac_rnd = {1'b0, w_frac} + {23'd0, w_round_up};
    assign w_exp_pre  = {2'b00, r_exp_a} + {2'b00, r_exp_b} - 10'd127 + {9'd0, w_norm};
    assign w_exp_fin  = w_exp_pre + {9'd0, w_frac_rnd[23]};

    always_comb begin
        w_result = {r_sign, w_exp_fin[7:0], w_frac_rnd[22:0]};
        case (r_special)
            SP_NAN:  w_result = 32'h7FC0_0000;
            SP_INF:  w_result = {r_sign, 8'hFF, 23'd0};
            SP_ZERO: w_result = {r_sign, 31'd0};
            default: begin
                if ($signed(w_exp_fin) >= 10'sd255)
                    w_result = {r_sign, 8'hFF, 23'd0};
                else if ($signed(w_exp_fin) <= 10'sd0)
                    w_result = {r_sign, 31'd0};
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_special    <= SP_NONE;
            r_sign       <= 1'b0;
            r_exp_a      <= '0;
            r_exp_b      <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
`ifdef FLOAT_MUL_NB_RADIX4_EN
            r_mcand3     <= '0;
`endif
        end else begin
            r_dout_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (din_valid) begin
                        r_special <= w_special;
                        r_sign    <= din1[31] ^ din2[31];
                        r_exp_a   <= din1[30:23];
                        r_exp_b   <= din2[30:23];
                        r_mcand   <= {24'd0, 1'b1, din1[22:0]};
                        r_mplier  <= {1'b1, din2[22:0]};
                        r_acc     <= '0;
                        r_cnt     <= '0;
`ifdef FLOAT_MUL_NB_RADIX4_EN
                        r_mcand3  <= {22'd0, w_a3};
`endif
                    end
                end
                MUL: begin
                    r_acc <= r_acc + w_addend;
                    r_cnt <= r_cnt + 5'd1;
`ifdef FLOAT_MUL_NB_RADIX4_EN
                    r_mcand  <= r_mcand << 2;
                    r_mcand3 <= r_mcand3 << 2;
                    r_mplier <= r_mplier >> 2;
`else
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
`endif
                end
                RND: begin
                    r_dout       <= w_result;
                    r_dout_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
endmodule

// File: tb/tb_float_mul_nb.sv
// Self-checking bench for float_mul_nb: directed vectors, control scenarios and random operands
// compared against a real-arithmetic reference model.
module tb_float_mul_nb;
`ifdef FLOAT_MUL_NB_RADIX4_EN
    localparam int EXP_LAT = 13;
`else
    localparam int EXP_LAT = 25;
`endif
    localparam int N_RANDOM = 1500;

    logic        clk;
    logic        nrst;
    logic [31:0] din1, din2;
    logic        din_valid;
    logic [31:0] dout;
    logic        dout_valid;
    int          nChecks = 0;
    int          nPass = 0;

    float_mul_nb dut (
        .clk        (clk),
        .nrst       (nrst),
        .din1       (din1),
        .din2       (din2),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: classify specials, otherwise form the exact product in double precision and round it to binary32
    function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sign, aNan, bNan, aInf, bInf, aZero, bZero, g, st;
        logic [63:0] da, db, pb;
        real         rp;
        int          ef;
        logic [23:0] m;
        sign  = a[31] ^ b[31];
        aNan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bNan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        aInf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bInf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        aZero = (a[30:23] == 8'h00);
        bZero = (b[30:23] == 8'h00);
        if (aNan || bNan) return 32'h7FC0_0000;
        if ((aInf && bZero) || (bInf && aZero)) return 32'h7FC0_0000;
        if (aInf || bInf) return {sign, 8'hFF, 23'd0};
        if (aZero || bZero) return {sign, 31'd0};
        da = {a[31], 11'({3'b000, a[30:23]} + 11'd896), a[22:0], 29'd0};
        db = {b[31], 11'({3'b000, b[30:23]} + 11'd896), b[22:0], 29'd0};
        rp = $bitstoreal(da) * $bitstoreal(db);
        pb = $realtobits(rp);
        ef = int'(pb[62:52]) - 896;
        m  = {1'b0, pb[51:29]};
        g  = pb[28];
        st = |pb[27:0];
        if (g && (st || m[0])) m = m + 24'd1;
        if (m[23]) ef = ef + 1;
        if (ef >= 255) return {sign, 8'hFF, 23'd0};
        if (ef <= 0) return {sign, 31'd0};
        return {sign, 8'(ef), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        v[31]    = 1'($urandom_range(0, 1));
        v[30:23] = 8'($urandom_range(100, 139));
        v[22:0]  = 23'($urandom);
        if ($urandom_range(0, 49) == 0) v[30:0] = '0;
        return v;
    endfunction

    // Launch one operation (captured at the next edge) and wait, bounded, for the result pulse
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res, output int lat);
        @(negedge clk);
        din1 = a;
        din2 = b;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din1 = $urandom;
        din2 = $urandom;
        lat = 0;
        res = 'x;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (dout_valid) begin
                lat = i;
                res = dout;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        din_valid = 1'b0;
        din1 = '0;
        din2 = '0;
        repeat (3) @(posedge clk);
        #1;
        nChecks++;
        if (dout !== 32'h0) $display("[TB] FAIL reset_dout got=%h want=%h", dout, 32'h0);
        else nPass++;
        nChecks++;
        if (dout_valid !== 1'b0) $display("[TB] FAIL reset_valid got=%b want=0", dout_valid);
        else nPass++;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] va[9]   = '{32'h3FC00000, 32'hC0400000, 32'h3F800001, 32'h7F000000, 32'h00800000,
                                 32'h80000000, 32'h7F800000, 32'h7FC00000, 32'hFF800000};
        logic [31:0] vb[9]   = '{32'h40000000, 32'h3F000000, 32'h3FC00000, 32'h40000000, 32'h3F000000,
                                 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h40000000};
        logic [31:0] vexp[9] = '{32'h40400000, 32'hBFC00000, 32'h3FC00002, 32'h7F800000, 32'h00000000,
                                 32'h80000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 9; i++) begin
            run_op(va[i], vb[i], res, lat);
            nChecks++;
            if (res !== vexp[i])
                $display("[TB] FAIL directed_%0d %h*%h got=%h want=%h", i, va[i], vb[i], res, vexp[i]);
            else nPass++;
        end
    endtask

    task automatic test_latency();
        logic [31:0] res;
        int          lat;
        run_op(32'h3FC00000, 32'h40000000, res, lat);
        nChecks++;
        if (lat != EXP_LAT) $display("[TB] FAIL latency got=%0d want=%0d", lat, EXP_LAT);
        else nPass++;
        @(posedge clk);
        #1;
        nChecks++;
        if (dout_valid !== 1'b0) $display("[TB] FAIL pulse_width valid_next_cycle got=%b want=0", dout_valid);
        else nPass++;
        repeat (3) @(posedge clk);
        #1;
        nChecks++;
        if (dout !== 32'h40400000) $display("[TB] FAIL dout_hold got=%h want=%h", dout, 32'h40400000);
        else nPass++;
    endtask

    task automatic test_ignore_midop();
        int          lat, pulses;
        logic [31:0] res;
        @(negedge clk);
        din1 = 32'hC0400000;
        din2 = 32'h3F000000;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        din1 = 32'h40000000;
        din2 = 32'h40000000;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        lat = 0;
        pulses = 0;
        res = 'x;
        for (int i = 6; i <= 70; i++) begin
            @(posedge clk);
            #1;
            if (dout_valid) begin
                pulses++;
                if (pulses == 1) begin
                    lat = i;
                    res = dout;
                end
            end
        end
        nChecks++;
        if (res !== 32'hBFC00000) $display("[TB] FAIL ignore_result got=%h want=%h", res, 32'hBFC00000);
        else nPass++;
        nChecks++;
        if (lat != EXP_LAT) $display("[TB] FAIL ignore_latency got=%0d want=%0d", lat, EXP_LAT);
        else nPass++;
        nChecks++;
        if (pulses != 1) $display("[TB] FAIL ignore_pulses got=%0d want=1", pulses);
        else nPass++;
    endtask

    task automatic test_reset_abort();
        int pulses;
        @(negedge clk);
        din1 = 32'h40400000;
        din2 = 32'h40400000;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        nChecks++;
        if (dout !== 32'h0 || dout_valid !== 1'b0)
            $display("[TB] FAIL abort_outputs got=%h/%b want=00000000/0", dout, dout_valid);
        else nPass++;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (dout_valid) pulses++;
        end
        nChecks++;
        if (pulses != 0 || dout !== 32'h0)
            $display("[TB] FAIL abort_no_result got pulses=%0d dout=%h want 0/00000000", pulses, dout);
        else nPass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        int          l1, l2;
        run_op(32'h3FC00000, 32'h40000000, r1, l1);
        run_op(32'hC0400000, 32'h3F000000, r2, l2);
        nChecks++;
        if (r1 !== 32'h40400000 || l1 != EXP_LAT)
            $display("[TB] FAIL b2b_first got=%h lat=%0d want=40400000 lat=%0d", r1, l1, EXP_LAT);
        else nPass++;
        nChecks++;
        if (r2 !== 32'hBFC00000 || l2 != EXP_LAT)
            $display("[TB] FAIL b2b_second got=%h lat=%0d want=BFC00000 lat=%0d", r2, l2, EXP_LAT);
        else nPass++;
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp;
        int          lat;
        for (int i = 0; i < N_RANDOM; i++) begin
            a = rand_operand();
            b = rand_operand();
            exp = model_mul(a, b);
            run_op(a, b, res, lat);
            nChecks++;
            if (res !== exp || lat != EXP_LAT)
                $display("[TB] FAIL random_%0d %h*%h got=%h lat=%0d want=%h lat=%0d", i, a, b, res, lat, exp, EXP_LAT);
            else nPass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_ignore_midop();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
